// File: rtl/rg_pkg.sv
// rg_pkg: shared definitions for the RG site sequencer.
//   - Nucleotide encoding (A=00, C=01, G=10, T=11).
//   - Default probability width and required row sum.
//   - Sequencer FSM state encoding.
package rg_pkg;

  localparam logic [1:0] NUC_A = 2'b00;
  localparam logic [1:0] NUC_C = 2'b01;
  localparam logic [1:0] NUC_G = 2'b10;
  localparam logic [1:0] NUC_T = 2'b11;

  localparam int unsigned PROB_W_DEF   = 10;
  localparam int unsigned PROB_SUM_DEF = 1000;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CHECK  = 3'd1,
    RD     = 3'd2,
    LOOKUP = 3'd3,
    WAIT   = 3'd4,
    WR     = 3'd5,
    DONE   = 3'd6
  } state_e;

endpackage

// File: rtl/rg_prob_matrix.sv
// rg_prob_matrix: 4x4 substitution-probability register file.
//   Row = parent nucleotide, column = child nucleotide.
//   Ports:
//     clk_i, reset_i   clock, synchronous active-high reset (loads identity)
//     idle_i           writes are accepted only while the sequencer is idle
//     we_i             entry write strobe
//     wr_row_i/col_i   entry coordinates
//     wr_data_i        entry value
//     rd_row_i         row selected for the read mux
//     rd_row_o         the four entries of the selected row, column 0 first
//     row_sum_ok_o     1 when every row sums exactly to PROB_SUM
module rg_prob_matrix
  import rg_pkg::*;
#(
  parameter int unsigned PROB_W   = PROB_W_DEF,
  parameter int unsigned PROB_SUM = PROB_SUM_DEF
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   idle_i,
  input  logic                   we_i,
  input  logic [1:0]             wr_row_i,
  input  logic [1:0]             wr_col_i,
  input  logic [PROB_W-1:0]      wr_data_i,
  input  logic [1:0]             rd_row_i,
  output logic [3:0][PROB_W-1:0] rd_row_o,
  output logic                   row_sum_ok_o
);

  // Sums are two bits wider than an entry so four maximal entries never wrap.
  localparam int unsigned SUM_W = PROB_W + 2;

  logic [3:0][3:0][PROB_W-1:0] mat_q;
  logic [3:0][SUM_W-1:0]       row_sum_s;
  logic [3:0]                  row_ok_s;

  // Matrix storage: identity on reset, single-entry write while idle.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int r = 0; r < 4; r++) begin
        for (int c = 0; c < 4; c++) begin
          mat_q[r][c] <= (r == c) ? PROB_W'(PROB_SUM) : {PROB_W{1'b0}};
        end
      end
    end else if (idle_i && we_i) begin
      mat_q[wr_row_i][wr_col_i] <= wr_data_i;
    end
  end

  // Full-width row sums and per-row validity.
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      row_sum_s[r] = SUM_W'(mat_q[r][0]) + SUM_W'(mat_q[r][1])
                   + SUM_W'(mat_q[r][2]) + SUM_W'(mat_q[r][3]);
      row_ok_s[r]  = (row_sum_s[r] == SUM_W'(PROB_SUM));
    end
  end

  assign row_sum_ok_o = &row_ok_s;
  assign rd_row_o     = mat_q[rd_row_i];

endmodule

// File: rtl/rg_site_sequencer.sv
// rg_site_sequencer: walks N sites of a parent sequence, drives the RG
// sampler with the parent's substitution row and writes RG's pick to the
// child memory.
//   Ports:
//     clk, reset                 clock, synchronous active-high reset
//     cfg_we/row/col/data        matrix entry write (honoured in IDLE only)
//     start, seq_len             begin a run of seq_len sites (IDLE only)
//     busy, done, cfg_err        run status; cfg_err sticky until next start
//     par_rd_en, par_addr        parent memory read (data one cycle later)
//     par_rdata                  parent nucleotide
//     prob_A/C/G/T               probability row presented to RG
//     rg_result                  RG sample, valid RG_LAT edges after prob
//     child_we/addr/wdata        child memory write
module rg_site_sequencer
  import rg_pkg::*;
#(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned PROB_W   = PROB_W_DEF,
  parameter int unsigned PROB_SUM = PROB_SUM_DEF,
  parameter int unsigned RG_LAT   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [1:0]        cfg_row,
  input  logic [1:0]        cfg_col,
  input  logic [PROB_W-1:0] cfg_data,
  input  logic              start,
  input  logic [ADDR_W-1:0] seq_len,
  output logic              busy,
  output logic              done,
  output logic              cfg_err,
  output logic              par_rd_en,
  output logic [ADDR_W-1:0] par_addr,
  input  logic [1:0]        par_rdata,
  output logic [PROB_W-1:0] prob_A,
  output logic [PROB_W-1:0] prob_C,
  output logic [PROB_W-1:0] prob_G,
  output logic [PROB_W-1:0] prob_T,
  input  logic [1:0]        rg_result,
  output logic              child_we,
  output logic [ADDR_W-1:0] child_addr,
  output logic [1:0]        child_wdata
);

  localparam int unsigned WCNT_W = (RG_LAT > 1) ? $clog2(RG_LAT) : 1;

  state_e                  state_q;
  logic [ADDR_W-1:0]       idx_q;
  logic [ADDR_W-1:0]       len_q;
  logic [WCNT_W-1:0]       wait_q;
  logic                    abort_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    cfg_err_q;
  logic                    par_rd_en_q;
  logic [ADDR_W-1:0]       par_addr_q;
  logic [3:0][PROB_W-1:0]  prob_q;
  logic                    child_we_q;
  logic [ADDR_W-1:0]       child_addr_q;
  logic [1:0]              wdata_hold_q;

  logic [3:0][PROB_W-1:0]  row_s;
  logic                    row_sum_ok_s;

  rg_prob_matrix #(
    .PROB_W   (PROB_W),
    .PROB_SUM (PROB_SUM)
  ) u_matrix (
    .clk_i        (clk),
    .reset_i      (reset),
    .idle_i       (state_q == IDLE),
    .we_i         (cfg_we),
    .wr_row_i     (cfg_row),
    .wr_col_i     (cfg_col),
    .wr_data_i    (cfg_data),
    .rd_row_i     (par_rdata),
    .rd_row_o     (row_s),
    .row_sum_ok_o (row_sum_ok_s)
  );

  // Sequencer FSM with all status/memory/RG outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      idx_q        <= {ADDR_W{1'b0}};
      len_q        <= {ADDR_W{1'b0}};
      wait_q       <= {WCNT_W{1'b0}};
      abort_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      cfg_err_q    <= 1'b0;
      par_rd_en_q  <= 1'b0;
      par_addr_q   <= {ADDR_W{1'b0}};
      prob_q       <= '0;
      child_we_q   <= 1'b0;
      child_addr_q <= {ADDR_W{1'b0}};
      wdata_hold_q <= 2'b00;
    end else begin
      // Strobes are single-cycle unless a state re-asserts them.
      par_rd_en_q <= 1'b0;
      child_we_q  <= 1'b0;
      done_q      <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            len_q     <= seq_len;
            idx_q     <= {ADDR_W{1'b0}};
            abort_q   <= 1'b0;
            cfg_err_q <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= CHECK;
          end
        end
        CHECK: begin
          // An aborted run lingers one extra cycle here so cfg_err is
          // already settled for a full cycle before the done pulse.
          if (abort_q) begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end else if (!row_sum_ok_s) begin
            cfg_err_q <= 1'b1;
            abort_q   <= 1'b1;
          end else if (len_q == {ADDR_W{1'b0}}) begin
            abort_q <= 1'b1;
          end else begin
            par_rd_en_q <= 1'b1;
            par_addr_q  <= idx_q;
            state_q     <= RD;
          end
        end
        RD: begin
          state_q <= LOOKUP;
        end
        LOOKUP: begin
          prob_q[0] <= row_s[NUC_A];
          prob_q[1] <= row_s[NUC_C];
          prob_q[2] <= row_s[NUC_G];
          prob_q[3] <= row_s[NUC_T];
          wait_q    <= {WCNT_W{1'b0}};
          state_q   <= WAIT;
        end
        WAIT: begin
          if (wait_q == WCNT_W'(RG_LAT - 1)) begin
            child_we_q   <= 1'b1;
            child_addr_q <= idx_q;
            state_q      <= WR;
          end else begin
            wait_q <= wait_q + {{(WCNT_W-1){1'b0}}, 1'b1};
          end
        end
        WR: begin
          wdata_hold_q <= rg_result;
          if (idx_q == len_q - {{(ADDR_W-1){1'b0}}, 1'b1}) begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            idx_q       <= idx_q + {{(ADDR_W-1){1'b0}}, 1'b1};
            par_rd_en_q <= 1'b1;
            par_addr_q  <= idx_q + {{(ADDR_W-1){1'b0}}, 1'b1};
            state_q     <= RD;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign cfg_err    = cfg_err_q;
  assign par_rd_en  = par_rd_en_q;
  assign par_addr   = par_addr_q;
  assign prob_A     = prob_q[0];
  assign prob_C     = prob_q[1];
  assign prob_G     = prob_q[2];
  assign prob_T     = prob_q[3];
  assign child_we   = child_we_q;
  assign child_addr = child_addr_q;
  // RG's result only becomes valid inside the WR cycle, so it is passed
  // through during WR and held from a register afterwards.
  assign child_wdata = child_we_q ? rg_result : wdata_hold_q;

endmodule

// File: tb/tb_rg_site_sequencer.sv
// Directed testbench for rg_site_sequencer with a deterministic RG model
// (picks the first column whose cumulative probability exceeds 500) and
// a registered parent memory.
module tb_rg_site_sequencer;

  localparam int ADDR_W = 10;
  localparam int PROB_W = 10;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              cfg_we = 1'b0;
  logic [1:0]        cfg_row = 2'b00;
  logic [1:0]        cfg_col = 2'b00;
  logic [PROB_W-1:0] cfg_data = '0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] seq_len = '0;
  logic              busy, done, cfg_err, par_rd_en, child_we;
  logic [ADDR_W-1:0] par_addr, child_addr;
  logic [1:0]        par_rdata = 2'b00;
  logic [PROB_W-1:0] prob_A, prob_C, prob_G, prob_T;
  logic [1:0]        rg_result = 2'b00;
  logic [1:0]        child_wdata;

  int checks = 0;
  int errors = 0;

  logic [1:0] par_mem [0:15];

  typedef struct {
    int addr;
    int data;
    int probc;
  } wr_rec_t;
  wr_rec_t wr_q[$];
  int n_rd = 0;
  int n_done = 0;

  rg_site_sequencer #(.ADDR_W(ADDR_W), .PROB_W(PROB_W), .PROB_SUM(1000), .RG_LAT(1)) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_row(cfg_row), .cfg_col(cfg_col),
    .cfg_data(cfg_data), .start(start), .seq_len(seq_len), .busy(busy), .done(done),
    .cfg_err(cfg_err), .par_rd_en(par_rd_en), .par_addr(par_addr), .par_rdata(par_rdata),
    .prob_A(prob_A), .prob_C(prob_C), .prob_G(prob_G), .prob_T(prob_T),
    .rg_result(rg_result), .child_we(child_we), .child_addr(child_addr),
    .child_wdata(child_wdata)
  );

  always #5 clk = ~clk;

  // RG model: one-edge latency, deterministic threshold sampler.
  always @(posedge clk) begin
    if (32'(prob_A) > 500) rg_result <= 2'b00;
    else if (32'(prob_A) + 32'(prob_C) > 500) rg_result <= 2'b01;
    else if (32'(prob_A) + 32'(prob_C) + 32'(prob_G) > 500) rg_result <= 2'b10;
    else rg_result <= 2'b11;
  end

  // Parent memory: data valid one cycle after the read enable.
  always @(posedge clk) begin
    if (par_rd_en) par_rdata <= par_mem[par_addr[3:0]];
  end

  // Monitor away from the active edge.
  always @(negedge clk) begin
    if (child_we === 1'b1) wr_q.push_back('{int'(child_addr), int'(child_wdata), int'(prob_C)});
    if (par_rd_en === 1'b1) n_rd++;
    if (done === 1'b1) n_done++;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cfg_write(input int r, input int c, input int d);
    @(negedge clk);
    cfg_we = 1'b1; cfg_row = 2'(r); cfg_col = 2'(c); cfg_data = PROB_W'(d);
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  // Drive start for one edge (E0); returns at E0 + 1ns.
  task automatic kick(input int len);
    @(negedge clk);
    seq_len = ADDR_W'(len); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int c0, output int cyc);
    cyc = c0;
    while (done !== 1'b1 && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic run(input string tag, input int len, input int exp_cyc);
    int cyc;
    kick(len);
    chk({tag, "_busy_at_start"}, int'(busy), 1);
    wait_done(0, cyc);
    chk({tag, "_done_edge"}, cyc, exp_cyc);
    chk({tag, "_busy_in_done"}, int'(busy), 1);
    @(posedge clk); #1;
    chk({tag, "_done_one_cycle"}, int'(done), 0);
    chk({tag, "_busy_after"}, int'(busy), 0);
  endtask

  initial begin
    int w0, r0, d0, cyc;

    // Reset
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_cfg_err", int'(cfg_err), 0);
    chk("rst_par_rd_en", int'(par_rd_en), 0);
    chk("rst_child_we", int'(child_we), 0);
    chk("rst_prob_A", int'(prob_A), 0);
    chk("rst_child_addr", int'(child_addr), 0);
    @(negedge clk);
    reset = 1'b0;

    // T1: identity matrix, parent A,C,G,T
    par_mem[0] = 2'b00; par_mem[1] = 2'b01; par_mem[2] = 2'b10; par_mem[3] = 2'b11;
    w0 = wr_q.size(); r0 = n_rd;
    run("t1", 4, 17);
    chk("t1_cfg_err", int'(cfg_err), 0);
    chk("t1_nwr", wr_q.size() - w0, 4);
    chk("t1_nrd", n_rd - r0, 4);
    for (int i = 0; i < 4; i++) begin
      if (w0 + i < wr_q.size()) begin
        chk($sformatf("t1_addr%0d", i), wr_q[w0+i].addr, i);
        chk($sformatf("t1_data%0d", i), wr_q[w0+i].data, i);
      end
    end

    // T2: row A reprogrammed to always produce C
    cfg_write(0, 0, 0); cfg_write(0, 1, 1000); cfg_write(0, 2, 0); cfg_write(0, 3, 0);
    par_mem[0] = 2'b00; par_mem[1] = 2'b00; par_mem[2] = 2'b00;
    w0 = wr_q.size();
    run("t2", 3, 13);
    chk("t2_nwr", wr_q.size() - w0, 3);
    for (int i = 0; i < 3; i++) begin
      if (w0 + i < wr_q.size()) begin
        chk($sformatf("t2_data%0d", i), wr_q[w0+i].data, 1);
        chk($sformatf("t2_probC%0d", i), wr_q[w0+i].probc, 1000);
      end
    end
    chk("t2_probC_held", int'(prob_C), 1000);
    chk("t2_probA_held", int'(prob_A), 0);

    // T3: row G sums to 500 -> error, no reads or writes
    cfg_write(2, 2, 500);
    w0 = wr_q.size(); r0 = n_rd;
    run("t3", 5, 2);
    chk("t3_cfg_err", int'(cfg_err), 1);
    chk("t3_nwr", wr_q.size() - w0, 0);
    chk("t3_nrd", n_rd - r0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("t3_cfg_err_sticky", int'(cfg_err), 1);
    cfg_write(2, 2, 1000);

    // T4: zero length
    w0 = wr_q.size(); r0 = n_rd;
    run("t4", 0, 2);
    chk("t4_cfg_err_cleared", int'(cfg_err), 0);
    chk("t4_nwr", wr_q.size() - w0, 0);
    chk("t4_nrd", n_rd - r0, 0);

    // T5: reset during WAIT of the second site
    par_mem[0] = 2'b00; par_mem[1] = 2'b00; par_mem[2] = 2'b00; par_mem[3] = 2'b00;
    w0 = wr_q.size(); d0 = n_done;
    kick(4);
    repeat (7) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("t5_busy", int'(busy), 0);
    chk("t5_done", int'(done), 0);
    chk("t5_par_rd_en", int'(par_rd_en), 0);
    chk("t5_child_we", int'(child_we), 0);
    chk("t5_probC", int'(prob_C), 0);
    chk("t5_child_addr", int'(child_addr), 0);
    chk("t5_child_wdata", int'(child_wdata), 0);
    chk("t5_nwr_before", wr_q.size() - w0, 1);
    if (wr_q.size() > w0) chk("t5_site0_data", wr_q[w0].data, 1);
    repeat (20) @(posedge clk);
    #1;
    chk("t5_no_more_wr", wr_q.size() - w0, 1);
    chk("t5_no_done", n_done - d0, 0);
    w0 = wr_q.size();
    run("t5b", 1, 5);
    chk("t5b_nwr", wr_q.size() - w0, 1);
    if (wr_q.size() > w0) chk("t5b_identity_A", wr_q[w0].data, 0);

    // T6: cfg_we and start during a run are ignored
    par_mem[0] = 2'b00; par_mem[1] = 2'b01; par_mem[2] = 2'b10; par_mem[3] = 2'b11;
    w0 = wr_q.size(); d0 = n_done;
    kick(4);
    repeat (3) @(posedge clk);
    @(negedge clk);
    cfg_we = 1'b1; cfg_row = 2'b00; cfg_col = 2'b11; cfg_data = PROB_W'(1000);
    start = 1'b1; seq_len = ADDR_W'(2);
    @(posedge clk); #1;
    cfg_we = 1'b0; start = 1'b0;
    wait_done(4, cyc);
    chk("t6_done_edge", cyc, 17);
    chk("t6_nwr", wr_q.size() - w0, 4);
    repeat (30) @(posedge clk);
    #1;
    chk("t6_no_second_run", n_done - d0, 1);
    chk("t6_idle_busy", int'(busy), 0);
    par_mem[0] = 2'b00;
    w0 = wr_q.size();
    run("t6b", 1, 5);
    chk("t6b_cfg_err", int'(cfg_err), 0);
    if (wr_q.size() > w0) chk("t6b_A_to_A", wr_q[w0].data, 0);
    else chk("t6b_nwr", wr_q.size() - w0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rg_site_sequencer.md
Name: rg_site_sequencer

Overview:
- Drives one RG nucleotide sampler across a sequence of N sites to produce a child sequence from a parent sequence.
- For each site it reads the parent nucleotide and selects that parent's row of a 4x4 substitution-probability matrix.
- It drives that row onto RG's prob_A..prob_T inputs, waits RG_LAT cycles, then writes RG's result to the child memory.
- It sits between the configuration/host side, which loads the matrix and issues start, and the RG/sequence memories.

Parameters:
- ADDR_W, 10, site address width; maximum sequence length 2^ADDR_W-1.
- PROB_W, 10, width of each probability entry.
- PROB_SUM, 1000, required sum of every matrix row.
- RG_LAT, 1, number of clock edges from stable prob inputs to a valid rg_result; must be at least 1.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cfg_we  in  1  matrix entry write strobe
- cfg_row  in  2  parent nucleotide (row)
- cfg_col  in  2  child nucleotide (column)
- cfg_data  in  PROB_W  entry value
- start  in  1  begin a run (sampled in IDLE only)
- seq_len  in  ADDR_W  number of sites; sampled with start
- busy  out  1  high from the start edge until the DONE cycle inclusive
- done  out  1  one-cycle completion pulse
- cfg_err  out  1  row-sum error of the last run; sticky until the next start
- par_rd_en  out  1  parent memory read enable
- par_addr  out  ADDR_W  parent read address
- par_rdata  in  2  parent nucleotide, valid one cycle after par_rd_en
- prob_A, prob_C, prob_G, prob_T  out  PROB_W each  to RG
- rg_result  in  2  from RG
- child_we  out  1  child memory write strobe
- child_addr  out  ADDR_W  child write address
- child_wdata  out  2  child nucleotide

Behaviour:
- Nucleotide encoding: A=00, C=01, G=10, T=11. Rows are indexed by parent nucleotide, columns by child nucleotide.
- Reset values:
  - Every output is 0.
  - FSM is in IDLE and the index register is 0.
  - Matrix is loaded with identity: diagonal = PROB_SUM, off-diagonal = 0.
- Reset applied mid-run aborts immediately: no further child_we, no done pulse, and the matrix returns to identity.
- cfg_we writes matrix[cfg_row][cfg_col] only in IDLE; it is ignored in every other state.
- start is ignored in any state other than IDLE.
- FSM sequence (E0 = the edge that samples start in IDLE):
  - IDLE -> CHECK on E0: latch seq_len, clear cfg_err, set busy.
  - CHECK: form the four row sums at PROB_W+2 bits, with no truncation.
    - Any row sum != PROB_SUM -> set cfg_err, go to DONE.
    - seq_len == 0 -> go to DONE.
    - Otherwise -> RD.
  - RD: par_rd_en=1, par_addr=idx, then -> LOOKUP.
  - LOOKUP: par_rdata is valid; register prob_A..T = matrix[par_rdata][0..3], then -> WAIT.
  - WAIT: count RG_LAT cycles with prob outputs held stable, then -> WR.
  - WR: child_we=1, child_addr=idx, child_wdata=rg_result.
    - idx == seq_len-1 -> DONE.
    - Otherwise idx++ and -> RD.
  - DONE: done=1 and busy=1 for exactly one cycle, then -> IDLE with busy=0.
- prob outputs hold their last value between sites and after the run; only reset or LOOKUP changes them.
- Timing:
  - Per-site cost is 3+RG_LAT cycles.
  - The DONE state is entered at edge E0+1+N*(3+RG_LAT).
  - On an error or N=0, DONE is entered at E0+2.
- Index wrap: idx never exceeds seq_len-1, so there is no wrap.
- Outside the WR cycle, child_we=0 and child_addr/child_wdata hold their previous values.
- par_rd_en is high only in RD.

Decomposition:
- Package rg_pkg:
  - Nucleotide encoding localparams NUC_A/C/G/T.
  - PROB_W and PROB_SUM defaults.
  - FSM state encoding: IDLE, CHECK, RD, LOOKUP, WAIT, WR, DONE.
- One natural sub-module: rg_prob_matrix.
  - Holds the 4x4 register file with identity reset and the IDLE-gated write port.
  - Provides a row-read mux and a combinational row_sum_ok output.
- The FSM, index counter and wait counter stay in rg_site_sequencer.

Test Plan:
- Identity matrix after reset:
  - Stimulus: parent memory = 00,01,10,11; seq_len=4; RG_LAT=1; real RG instance.
  - Response: child writes (0,00), (1,01), (2,10), (3,11); done high in the cycle after E0+17; cfg_err=0.
- Reprogrammed row A:
  - Stimulus: write A-row = {0,1000,0,0}; parent = 00,00,00; seq_len=3.
  - Response: child all 01; prob_C=1000 driven during every WAIT; done after E0+13.
- Row-sum error:
  - Stimulus: write matrix[G][G]=500; start with seq_len=5.
  - Response: cfg_err=1; done pulse after E0+2; zero child_we pulses; par_rd_en never asserted.
- Zero length:
  - Stimulus: seq_len=0.
  - Response: done after E0+2; cfg_err=0; no reads and no writes.
- Mid-run reset:
  - Stimulus: seq_len=4; assert reset for 1 cycle during WAIT of site 2.
  - Response: busy=0 and all outputs 0 on the next edge; no further child_we; matrix reads back as identity; a new start with seq_len=1 completes correctly.
- Busy protection:
  - Stimulus: during a run, pulse cfg_we with matrix[A][T]=1000 and pulse start.
  - Response: the matrix is unchanged (a later identity run still maps A->A), and no second run begins.
